inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the instruction memory (depth 2**ADDR_W 32-bit words).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a program load; sampled each cycle.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  program byte; instruction words arrive little-endian (byte 0 = bits 7:0).
REQ-007 in_last  input  1  marks the final byte of the program; qualified by in_valid.
REQ-008 in_ready  output  1  byte-stream ready; a byte transfers on an edge where in_valid and in_ready are both 1.
REQ-009 imem_we  output  1  registered one-cycle instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  word address for the write.
REQ-011 imem_wdata  output  32  assembled instruction word.
REQ-012 cpu_rst_n  output  1  active-low reset driven to the CPU core; low unless a load has completed.
REQ-013 busy  output  1  high while in LOAD.
REQ-014 done  output  1  high while in DONE.
REQ-015 err  output  1  high while in ERR.
REQ-016 load_words  output  ADDR_W+1  number of words written by the current/last load.

Function
REQ-017 FSM states IDLE, LOAD, DONE, ERR; busy/done/err are decoded from the state register.
REQ-018 IDLE -> LOAD on start=1; DONE -> LOAD and ERR -> LOAD on start=1; start ignored in LOAD.
REQ-019 Entering LOAD clears byte counter (2 bits), word counter, and load_words to 0.
REQ-020 in_ready = 1 only in LOAD; 0 in IDLE, DONE, ERR.
REQ-021 Each transferred byte is placed in byte lane byte_cnt of a 32-bit assembly buffer; byte_cnt increments mod 4.
REQ-022 On the transfer with byte_cnt=3: next cycle imem_we=1, imem_wdata={in_data, buffer[23:0]}, imem_addr=word counter; word counter and load_words increment on the same edge.
REQ-023 imem_we is high for exactly one cycle per completed word; back-to-back bytes every cycle sustain one word every 4 cycles with no stall.
REQ-024 imem_addr and imem_wdata hold their last values when imem_we=0.
REQ-025 in_last with byte_cnt=3: the word is written per REQ-022 and state -> DONE on that edge.
REQ-026 in_last with byte_cnt!=3: no write of the partial word; state -> ERR.
REQ-027 Overflow: word written at address 2**ADDR_W-1 without in_last -> state -> ERR on that edge (that word is still written).
REQ-028 cpu_rst_n is a register set to 1 on the edge after state becomes DONE (i.e., the cycle after the final imem_we), and cleared to 0 on the edge the state leaves DONE.
REQ-029 In ERR, cpu_rst_n stays 0, and load_words holds the count of words written.
REQ-030 in_valid while in_ready=0 is ignored; no byte consumed.

Reset
REQ-031 rst_n=0 asynchronously forces state IDLE, cpu_rst_n=0, imem_we=0, imem_addr=0, imem_wdata=0, load_words=0, in_ready=0, busy=0, done=0, err=0, counters=0.
REQ-032 Reset asserted mid-LOAD aborts the load immediately; no further imem_we until a new start after reset release.

Verification
REQ-033 Reset: assert rst_n=0 mid-cycle -> all outputs at REQ-031 values without waiting for clk.
REQ-034 start, then bytes 78,56,34,12,EF,BE,AD,DE every cycle, in_last on DE -> writes addr0=0x12345678, addr1=0xDEADBEEF; done=1, load_words=2; cpu_rst_n=1 one cycle after second imem_we.
REQ-035 Same stream with in_valid deasserted for 3 random gaps -> identical writes and final state.
REQ-036 start, bytes 01,02 with in_last on 02 -> no imem_we, err=1, cpu_rst_n=0, load_words=0; then start plus a valid 4-byte program -> done=1.
REQ-037 ADDR_W=2, 5 words streamed without in_last -> 4 writes at addr 0..3, err=1 after the 4th, load_words=4, in_ready=0.
REQ-038 From DONE, start -> cpu_rst_n drops to 0 the next edge, busy=1; rst_n pulsed low during byte 2 of a word -> IDLE, no write issued.

Source files
------------

// File: rtl/inst_loader.sv
// Instruction loader: assembles a little-endian byte stream into 32-bit
// words, writes them to instruction memory, then releases the CPU reset.
module inst_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   load_words
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [23:0]       asm_buf;
  logic              xfer;
  logic              word_end;
  logic              at_top;
  logic              enter_load;

  assign in_ready   = (state == LOAD);
  assign busy       = (state == LOAD);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign xfer       = in_valid & in_ready;
  assign word_end   = xfer & (byte_cnt == 2'd3);
  assign at_top     = &word_cnt;
  assign enter_load = (state != LOAD) & (state_nx == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // in_last wins over overflow: a program that exactly fills memory is good
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        if (xfer && in_last) begin
          state_nx = (byte_cnt == 2'd3) ? DONE : ERR;
        end else if (word_end && at_top) begin
          state_nx = ERR;
        end
      end
      DONE: begin
        if (start) state_nx = LOAD;
      end
      ERR: begin
        if (start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 2'd0;
      word_cnt   <= '0;
      asm_buf    <= 24'd0;
      load_words <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_rst_n  <= 1'b0;
    end else begin
      imem_we   <= word_end;
      cpu_rst_n <= (state == DONE) && (state_nx == DONE);
      if (enter_load) begin
        byte_cnt   <= 2'd0;
        word_cnt   <= '0;
        asm_buf    <= 24'd0;
        load_words <= '0;
      end else if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        unique case (byte_cnt)
          2'd0: asm_buf[7:0]   <= in_data;
          2'd1: asm_buf[15:8]  <= in_data;
          2'd2: asm_buf[23:16] <= in_data;
          2'd3: begin
            imem_wdata <= {in_data, asm_buf};
            imem_addr  <= word_cnt;
            word_cnt   <= word_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            load_words <= load_words + {{ADDR_W{1'b0}}, 1'b1};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed scenarios with random data and gaps,
// checked against a word-grouping model of the byte stream.
module tb_inst_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_ready, imem_we, cpu_rst_n, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  load_words;

  logic        b_start = 1'b0;
  logic        b_valid = 1'b0;
  logic [7:0]  b_data = 8'd0;
  logic        b_last = 1'b0;
  logic        b_ready, b_we, b_crst, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_lw;

  int n_chk = 0;
  int n_fail = 0;
  logic [39:0] wq[$];
  logic [33:0] wqb[$];

  always #5 clk = ~clk;

  inst_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .busy(busy),
    .done(done), .err(err), .load_words(load_words)
  );

  inst_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
    .in_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .cpu_rst_n(b_crst), .busy(b_busy),
    .done(b_done), .err(b_err), .load_words(b_lw)
  );

  always @(negedge clk) if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
  always @(negedge clk) if (b_we === 1'b1) wqb.push_back({b_addr, b_wdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".we"}, 64'(imem_we), 64'd0);
    chk({tag, ".addr"}, 64'(imem_addr), 64'd0);
    chk({tag, ".wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, ".lw"}, 64'(load_words), 64'd0);
    chk({tag, ".crst"}, 64'(cpu_rst_n), 64'd0);
    chk({tag, ".flags"}, 64'({in_ready, busy, done, err}), 64'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_stream(input bq_t bs, input bit last, input int ngaps);
    bit g[64];
    int cnt = 0;
    for (int i = 0; i < 64; i++) g[i] = 1'b0;
    while (cnt < ngaps) begin
      int p = $urandom_range(1, bs.size() - 1);
      if (!g[p]) begin g[p] = 1'b1; cnt++; end
    end
    for (int i = 0; i < bs.size(); i++) begin
      if (g[i]) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_last = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = bs[i];
      in_last = last && (i == bs.size() - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last = 1'b0;
    end
  endtask

  // Model: complete 4-byte groups become words; a clean finish needs a
  // whole number of words ending on in_last.
  task automatic check_prog(input string tag, input bq_t bs, input bit last);
    int n = bs.size();
    int words = n / 4;
    bit ok = last && (n % 4 == 0);
    chk({tag, ".nwr"}, 64'(wq.size()), 64'(words));
    for (int i = 0; i < words && i < wq.size(); i++) begin
      logic [39:0] e;
      e = {8'(i), bs[4*i+3], bs[4*i+2], bs[4*i+1], bs[4*i]};
      chk($sformatf("%s.w%0d", tag, i), 64'(wq[i]), 64'(e));
    end
    chk({tag, ".done"}, 64'(done), 64'(ok));
    chk({tag, ".err"}, 64'(err), 64'(!ok));
    chk({tag, ".lw"}, 64'(load_words), 64'(words));
    chk({tag, ".crst"}, 64'(cpu_rst_n), 64'(ok));
  endtask

  initial begin
    bq_t p34, p36, rnd;
    #1;
    chk_reset("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle.ready", 64'(in_ready), 64'd0);

    // Basic two-word program
    p34 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wq.delete();
    do_start();
    chk("load.busy", 64'(busy), 64'd1);
    send_stream(p34, 1'b1, 0);
    chk("fin.we", 64'(imem_we), 64'd1);
    chk("fin.crst_lo", 64'(cpu_rst_n), 64'd0);
    @(posedge clk); #1;
    chk("fin.crst_hi", 64'(cpu_rst_n), 64'd1);
    chk("fin.we_lo", 64'(imem_we), 64'd0);
    repeat (2) @(posedge clk); #1;
    check_prog("p34", p34, 1'b1);

    // Restart from DONE, then reset partway through a word
    do_start();
    chk("rs.crst", 64'(cpu_rst_n), 64'd0);
    chk("rs.busy", 64'(busy), 64'd1);
    chk("rs.lw", 64'(load_words), 64'd0);
    wq.delete();
    rnd = '{8'($urandom), 8'($urandom)};
    send_stream(rnd, 1'b0, 0);
    in_valid = 1'b1;
    in_data = 8'($urandom);
    #3 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    #2 rst_n = 1'b1;
    repeat (6) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("rs.nwr", 64'(wq.size()), 64'd0);
    chk("rs.idle", 64'({busy, done, err, in_ready}), 64'd0);

    // Same program with random stalls
    wq.delete();
    do_start();
    send_stream(p34, 1'b1, 3);
    repeat (2) @(posedge clk); #1;
    check_prog("gap", p34, 1'b1);

    // Random-length program with stalls
    rnd.delete();
    repeat (4 * $urandom_range(2, 6)) rnd.push_back(8'($urandom));
    wq.delete();
    do_start();
    send_stream(rnd, 1'b1, 3);
    repeat (2) @(posedge clk); #1;
    check_prog("rnd", rnd, 1'b1);

    // Truncated program, then recovery
    p36 = '{8'h01, 8'h02};
    wq.delete();
    do_start();
    send_stream(p36, 1'b1, 0);
    repeat (2) @(posedge clk); #1;
    check_prog("trunc", p36, 1'b1);
    rnd.delete();
    repeat (4) rnd.push_back(8'($urandom));
    wq.delete();
    do_start();
    send_stream(rnd, 1'b1, 0);
    repeat (2) @(posedge clk); #1;
    check_prog("recov", rnd, 1'b1);

    // Overflow on the 4-word instance
    rnd.delete();
    repeat (20) rnd.push_back(8'($urandom));
    wqb.delete();
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b_valid = 1'b1;
      b_data = rnd[i];
      @(posedge clk); #1;
      if (i == 15) begin
        chk("ovf.err_at16", 64'(b_err), 64'd1);
        chk("ovf.we_at16", 64'(b_we), 64'd1);
      end
    end
    b_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("ovf.nwr", 64'(wqb.size()), 64'd4);
    for (int i = 0; i < 4 && i < wqb.size(); i++) begin
      logic [33:0] e;
      e = {2'(i), rnd[4*i+3], rnd[4*i+2], rnd[4*i+1], rnd[4*i]};
      chk($sformatf("ovf.w%0d", i), 64'(wqb[i]), 64'(e));
    end
    chk("ovf.err", 64'(b_err), 64'd1);
    chk("ovf.lw", 64'(b_lw), 64'd4);
    chk("ovf.ready", 64'(b_ready), 64'd0);
    chk("ovf.crst", 64'(b_crst), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
